dipsw_debounce_dev: RTL

//  Bridge-slot input device for the 32 DIP switches (DEV1 slot); replaces the bare combinational switch read.

---
 rtl/dipsw_debounce_dev_pkg.sv | 21 ++
 rtl/dsw_filter_bit.sv | 53 +++++
 rtl/dipsw_debounce_dev.sv | 103 ++++++++++
 3 files changed

// File: rtl/dipsw_debounce_dev_pkg.sv
// Shared register map and CTRL layout for the DIP-switch bridge device.
package dipsw_debounce_dev_pkg;

    localparam logic [1:0] DSW_DATA = 2'd0;
    localparam logic [1:0] DSW_CHG  = 2'd1;
    localparam logic [1:0] DSW_MASK = 2'd2;
    localparam logic [1:0] DSW_CTRL = 2'd3;

    localparam int unsigned DSW_CTRL_DB_EN  = 0;
    localparam int unsigned DSW_CTRL_IRQ_EN = 1;

    typedef struct packed {
        logic irq_en;
        logic db_en;
    } dsw_ctrl_t;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/dsw_filter_bit.sv
// One switch input: two-FF synchroniser, tick-sampled history and the accepted level.
module dsw_filter_bit #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic sys_clk,
    input  logic RST,
    input  logic i_pin,
    input  logic i_tick,
    input  logic i_db_en,
    output logic o_level,
    output logic o_toggle
);

    logic [1:0]            r_sync;
    logic [STABLE_CNT-1:0] r_hist;
    logic                  r_level;
    logic [STABLE_CNT-1:0] w_hist_nxt;
    logic                  w_level_nxt;

    assign w_hist_nxt = {r_hist[STABLE_CNT-2:0], r_sync[1]};

    // The history keeps shifting in bypass so re-enabling the filter starts from real samples.
    always_comb begin
        w_level_nxt = r_level;
        if (!i_db_en) begin
            w_level_nxt = r_sync[1];
        end else if (i_tick) begin
            if (&w_hist_nxt) begin
                w_level_nxt = 1'b1;
            end else if (~|w_hist_nxt) begin
                w_level_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge RST) begin
        if (!RST) begin
            r_sync  <= '0;
            r_hist  <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_pin};
            if (i_tick) begin
                r_hist <= w_hist_nxt;
            end
            r_level <= w_level_nxt;
        end
    end

    assign o_level  = r_level;
    assign o_toggle = w_level_nxt ^ r_level;

endmodule

// File: rtl/dipsw_debounce_dev.sv
// DIP-switch bridge device: debounced levels, sticky change flags, masked level IRQ.
module dipsw_debounce_dev
    import dipsw_debounce_dev_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic             sys_clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] dipsw,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [31:0]      wd,
    input  logic [3:0]       be,
    output logic [31:0]      rd,
    output logic             irq
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);

    logic [PRESC_W-1:0] r_presc;
    logic [WIDTH-1:0]   r_chg;
    logic [WIDTH-1:0]   r_mask;
    dsw_ctrl_t          r_ctrl;

    logic               w_tick;
    logic [WIDTH-1:0]   w_level;
    logic [WIDTH-1:0]   w_toggle;
    logic [31:0]        w_be_mask;
    logic [WIDTH-1:0]   w_wmask;
    logic               w_wr_chg;
    logic               w_wr_mask;
    logic               w_wr_ctrl;
    logic [WIDTH-1:0]   w_chg_clr;

    assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge sys_clk or negedge RST) begin
        if (!RST) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        dsw_filter_bit #(
            .STABLE_CNT(STABLE_CNT)
        ) u_filter (
            .sys_clk (sys_clk),
            .RST     (RST),
            .i_pin   (dipsw[gi]),
            .i_tick  (w_tick),
            .i_db_en (r_ctrl.db_en),
            .o_level (w_level[gi]),
            .o_toggle(w_toggle[gi])
        );
    end

    assign w_be_mask = be_to_mask(be);
    assign w_wmask   = w_be_mask[WIDTH-1:0];
    assign w_wr_chg  = we && (addr == DSW_CHG);
    assign w_wr_mask = we && (addr == DSW_MASK);
    assign w_wr_ctrl = we && (addr == DSW_CTRL);
    assign w_chg_clr = w_wr_chg ? (wd[WIDTH-1:0] & w_wmask) : '0;

    // Clear is applied before set so a toggle in the same cycle as a W1C survives.
    always_ff @(posedge sys_clk or negedge RST) begin
        if (!RST) begin
            r_chg  <= '0;
            r_mask <= '0;
            r_ctrl <= '{irq_en: 1'b0, db_en: 1'b1};
        end else begin
            r_chg <= (r_chg & ~w_chg_clr) | w_toggle;
            if (w_wr_mask) begin
                r_mask <= (r_mask & ~w_wmask) | (wd[WIDTH-1:0] & w_wmask);
            end
            if (w_wr_ctrl && be[0]) begin
                r_ctrl <= '{irq_en: wd[DSW_CTRL_IRQ_EN], db_en: wd[DSW_CTRL_DB_EN]};
            end
        end
    end

    always_comb begin
        rd = '0;
        unique case (addr)
            DSW_DATA: rd = 32'(w_level);
            DSW_CHG:  rd = 32'(r_chg);
            DSW_MASK: rd = 32'(r_mask);
            DSW_CTRL: begin
                rd[DSW_CTRL_DB_EN]  = r_ctrl.db_en;
                rd[DSW_CTRL_IRQ_EN] = r_ctrl.irq_en;
            end
            default: rd = '0;
        endcase
    end

    assign irq = r_ctrl.irq_en & (|(r_chg & r_mask));

endmodule
